// File: rtl/coffee_order_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : coffee_order_ctrl_if
// Purpose  : Order handshake and brewer control bundle for coffee_order_ctrl.
//            The slave side is the controller; the master side is the order
//            source plus the brewer.
// Revision : 1.0  initial release
// ============================================================================
interface coffee_order_ctrl_if;
    logic       order_valid;
    logic [1:0] order_sel;
    logic       order_ready;
    logic [2:0] fsm_state;
    logic       fsm_done;
    logic       start;
    logic [1:0] coffee_sel;

    modport master (
        output order_valid,
        output order_sel,
        output fsm_state,
        output fsm_done,
        input  order_ready,
        input  start,
        input  coffee_sel
    );

    modport slave (
        input  order_valid,
        input  order_sel,
        input  fsm_state,
        input  fsm_done,
        output order_ready,
        output start,
        output coffee_sel
    );
endinterface
`default_nettype wire

// File: rtl/coffee_order_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : coffee_order_ctrl
// Purpose  : Buffers up to four drink orders and feeds them one at a time to
//            the brewer, with acknowledge timeout, served counter and error
//            flags.
// Revision : 1.0  initial release
// ============================================================================
module coffee_order_ctrl (
    input  logic               clk,
    input  logic               reset,
    coffee_order_ctrl_if.slave bus,
    output logic               busy,
    output logic [2:0]         queue_count,
    output logic [7:0]         served_count,
    output logic               err_sel,
    output logic               timeout_err
);

    localparam logic [2:0] C_FIFO_DEPTH   = 3'd4;
    localparam logic [1:0] C_SEL_INVALID  = 2'b11;
    // Last ack-counter value before it reaches 7 and the wait is abandoned.
    localparam logic [2:0] C_ACK_LAST     = 3'd6;
    localparam logic [7:0] C_SERVED_MAX   = 8'hFF;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT_ACK  = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_GAP       = 3'd4
    } state_t;

    state_t     r_state;
    logic [1:0] r_fifo [0:3];
    logic [1:0] r_wr_ptr;
    logic [1:0] r_rd_ptr;
    logic [2:0] r_count;
    logic [2:0] r_ack_cnt;
    logic       r_start;
    logic [1:0] r_coffee_sel;
    logic       r_busy;
    logic [7:0] r_served;
    logic       r_err_sel;
    logic       r_timeout_err;

    logic       w_ready;
    logic       w_xfer;
    logic       w_push;
    logic       w_pop;

    // Handshake decode: an invalid code still completes the transfer but is
    // never stored.  The entry issued to the brewer leaves the FIFO on the
    // edge that ends the ISSUE cycle.
    assign w_ready = (r_count < C_FIFO_DEPTH);
    assign w_xfer  = bus.order_valid & w_ready;
    assign w_push  = w_xfer & (bus.order_sel != C_SEL_INVALID);
    assign w_pop   = (r_state == S_ISSUE);

    assign bus.order_ready = w_ready;
    assign bus.start       = r_start;
    assign bus.coffee_sel  = r_coffee_sel;
    assign busy            = r_busy;
    assign queue_count     = r_count;
    assign served_count    = r_served;
    assign err_sel         = r_err_sel;
    assign timeout_err     = r_timeout_err;

    // FIFO storage; contents are don't-care while the pointers say empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= bus.order_sel;
        end
    end

    // FIFO pointers, occupancy and the invalid-order pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr  <= 2'd0;
            r_rd_ptr  <= 2'd0;
            r_count   <= 3'd0;
            r_err_sel <= 1'b0;
        end else begin
            r_err_sel <= w_xfer & (bus.order_sel == C_SEL_INVALID);
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 2'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 2'd1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Controller FSM with registered start/busy/coffee_sel and status flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_ack_cnt     <= 3'd0;
            r_start       <= 1'b0;
            r_coffee_sel  <= 2'b00;
            r_busy        <= 1'b0;
            r_served      <= 8'd0;
            r_timeout_err <= 1'b0;
        end else begin
            r_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (r_count != 3'd0) begin
                        r_state      <= S_ISSUE;
                        r_start      <= 1'b1;
                        r_coffee_sel <= r_fifo[r_rd_ptr];
                        r_busy       <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    r_state   <= S_WAIT_ACK;
                    r_ack_cnt <= 3'd0;
                end
                S_WAIT_ACK: begin
                    if (bus.fsm_state != 3'd0) begin
                        r_state <= S_WAIT_DONE;
                    end else begin
                        r_ack_cnt <= r_ack_cnt + 3'd1;
                        // Brewer never left IDLE: drop the order for good.
                        if (r_ack_cnt == C_ACK_LAST) begin
                            r_state       <= S_IDLE;
                            r_busy        <= 1'b0;
                            r_timeout_err <= 1'b1;
                        end
                    end
                end
                S_WAIT_DONE: begin
                    if (bus.fsm_done) begin
                        r_state <= S_GAP;
                        if (r_served != C_SERVED_MAX) begin
                            r_served <= r_served + 8'd1;
                        end
                    end
                end
                S_GAP: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_coffee_order_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_coffee_order_ctrl
// Purpose  : Randomized self-checking bench for coffee_order_ctrl with an
//            order-queue reference model and a reactive brewer model.
// Revision : 1.0  initial release
// ============================================================================
module tb_coffee_order_ctrl;

    localparam int P_IDLE      = 0;
    localparam int P_ISSUE     = 1;
    localparam int P_WAIT_ACK  = 2;
    localparam int P_WAIT_DONE = 3;
    localparam int P_GAP       = 4;
    localparam int ACK_WINDOW  = 7;

    logic       clk = 1'b0;
    logic       reset;
    logic       busy;
    logic [2:0] queue_count;
    logic [7:0] served_count;
    logic       err_sel;
    logic       timeout_err;

    coffee_order_ctrl_if bus ();

    coffee_order_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .busy         (busy),
        .queue_count  (queue_count),
        .served_count (served_count),
        .err_sel      (err_sel),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    int n_checks;
    int n_errors;

    // Reference model: pending orders, what the controller is doing with
    // the current drink, and the status it has reported.
    int m_q[$];
    int m_ph;
    int m_ack;
    int m_sel;
    int m_served;
    bit m_tmo;
    bit m_err;

    // Brewer model.
    int b_ph;
    int b_cnt;
    int b_d;
    int b_len;
    bit b_never;

    // Stimulus knobs.
    int valid_pct;
    bit fast;
    bit quiet;
    bit hold_pending;
    int hold_sel;

    task automatic check(input string tag, input logic [31:0] got, input int exp);
        n_checks++;
        if (got !== 32'(exp)) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check("order_ready",  bus.order_ready, int'(m_q.size() < 4));
        check("queue_count",  queue_count,     m_q.size());
        check("start",        bus.start,       int'(m_ph == P_ISSUE));
        check("coffee_sel",   bus.coffee_sel,  m_sel);
        check("busy",         busy,            int'(m_ph != P_IDLE));
        check("served_count", served_count,    m_served);
        check("err_sel",      err_sel,         int'(m_err));
        check("timeout_err",  timeout_err,     int'(m_tmo));
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ph            = P_IDLE;
        m_ack           = 0;
        m_sel           = 0;
        m_served        = 0;
        m_tmo           = 1'b0;
        m_err           = 1'b0;
        b_ph            = 0;
        b_cnt           = 0;
        hold_pending    = 1'b0;
        bus.fsm_state   = 3'd0;
        bus.fsm_done    = 1'b0;
        bus.order_valid = 1'b0;
        bus.order_sel   = 2'b00;
    endtask

    // Drive this cycle's inputs, then move the model to the next cycle.
    task automatic drive_and_advance();
        int  sz;
        bit  xfer;
        int  sel;

        if (hold_pending) begin
            bus.order_valid = 1'b1;
            bus.order_sel   = 2'(hold_sel);
        end else if (!quiet && $urandom_range(99) < valid_pct) begin
            bus.order_valid = 1'b1;
            bus.order_sel   = ($urandom_range(15) == 0) ? 2'b11 : 2'($urandom_range(2));
        end else begin
            bus.order_valid = 1'b0;
            bus.order_sel   = 2'($urandom_range(3));
        end

        bus.fsm_done = 1'b0;
        case (b_ph)
            0: begin
                bus.fsm_state = 3'd0;
                bus.fsm_done  = ($urandom_range(7) == 0);
                if (bus.start === 1'b1) begin
                    b_ph    = 1;
                    b_cnt   = 0;
                    b_never = !fast && ($urandom_range(4) == 0);
                    b_d     = fast ? 0 : int'($urandom_range(ACK_WINDOW - 1));
                end
            end
            1: begin
                if (!b_never && b_cnt == b_d) begin
                    bus.fsm_state = 3'($urandom_range(7, 1));
                    b_ph  = 2;
                    b_len = fast ? 0 : int'($urandom_range(3));
                end else begin
                    bus.fsm_state = 3'd0;
                    b_cnt++;
                    if (b_never && b_cnt == ACK_WINDOW) b_ph = 0;
                end
            end
            2: begin
                if (b_len == 0) begin
                    bus.fsm_done = 1'b1;
                    b_ph = 3;
                end else begin
                    b_len--;
                end
            end
            default: begin
                bus.fsm_state = 3'd0;
                b_ph = 0;
            end
        endcase

        sz           = m_q.size();
        sel          = int'(bus.order_sel);
        xfer         = bus.order_valid && (sz < 4);
        m_err        = xfer && (sel == 3);
        hold_pending = bus.order_valid && !(sz < 4);
        hold_sel     = sel;

        case (m_ph)
            P_IDLE: begin
                if (sz > 0) begin
                    m_ph  = P_ISSUE;
                    m_sel = m_q[0];
                end
            end
            P_ISSUE: begin
                m_ph  = P_WAIT_ACK;
                m_ack = 0;
                void'(m_q.pop_front());
            end
            P_WAIT_ACK: begin
                if (bus.fsm_state != 3'd0) begin
                    m_ph = P_WAIT_DONE;
                end else begin
                    m_ack++;
                    if (m_ack == ACK_WINDOW) begin
                        m_ph  = P_IDLE;
                        m_tmo = 1'b1;
                    end
                end
            end
            P_WAIT_DONE: begin
                if (bus.fsm_done) begin
                    m_ph = P_GAP;
                    if (m_served < 255) m_served++;
                end
            end
            default: m_ph = P_IDLE;
        endcase

        if (xfer && sel != 3) m_q.push_back(sel);
    endtask

    task automatic cycle();
        @(negedge clk);
        check_outputs();
        drive_and_advance();
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    initial begin
        bit found;
        n_checks  = 0;
        n_errors  = 0;
        valid_pct = 40;
        fast      = 1'b0;
        quiet     = 1'b0;
        reset     = 1'b0;
        model_reset();

        // Reset state, with an order offered while reset is held.
        bus.order_valid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_outputs();
        bus.order_valid = 1'b0;
        reset = 1'b1;
        drive_and_advance();

        run(300);
        valid_pct = 90;
        run(300);

        // Reset while brewing with orders still queued.
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            cycle();
            if (m_ph == P_WAIT_DONE && m_q.size() >= 2) found = 1'b1;
        end
        check("midbrew_found", found, 1);
        @(posedge clk);
        #1;
        check("busy_before_rst", busy, 1);
        #1;
        reset = 1'b0;
        #1;
        model_reset();
        check_outputs();
        bus.order_valid = 1'b1;
        bus.order_sel   = 2'b01;
        repeat (2) begin
            @(negedge clk);
            check_outputs();
        end
        reset = 1'b1;
        quiet = 1'b1;
        drive_and_advance();
        run(12);
        quiet = 1'b0;

        // Fast brewer keeps the queue moving long enough to saturate.
        fast      = 1'b1;
        valid_pct = 90;
        run(2000);
        check("served_sat", served_count, 255);

        fast      = 1'b0;
        valid_pct = 30;
        run(500);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
